control_sequencer: RTL and testbench

//  Fetch/execute controller of the 16-bit SAP CPU. Consumer of the instruction register: drives ir_write

---
 rtl/sap_pkg.sv | 44 ++++
 rtl/ctrl_decode.sv | 109 ++++++++++
 rtl/control_sequencer.sv | 105 ++++++++++
 tb/tb_control_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP CPU fetch/execute controller:
// opcodes, state encoding and control-word bit positions.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH0 = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_EXEC0  = 3'd2,
        ST_EXEC1  = 3'd3,
        ST_EXEC2  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Control-word bit positions; bus drivers first so the one-hot group is contiguous.
    localparam int CW_PC_OE       = 0;
    localparam int CW_IR_ADDR_OE  = 1;
    localparam int CW_RAM_OE      = 2;
    localparam int CW_A_OE        = 3;
    localparam int CW_ALU_OE      = 4;
    localparam int CW_MAR_WRITE   = 5;
    localparam int CW_IR_WRITE    = 6;
    localparam int CW_A_WRITE     = 7;
    localparam int CW_B_WRITE     = 8;
    localparam int CW_RAM_WRITE   = 9;
    localparam int CW_OUT_WRITE   = 10;
    localparam int CW_FLAGS_WRITE = 11;
    localparam int CW_PC_INC      = 12;
    localparam int CW_PC_LOAD     = 13;
    localparam int CW_ALU_SUB     = 14;
    localparam int CW_W           = 15;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of {state, opcode, flags} into the control word,
// plus flags marking the final execute cycle and a transition into HALT.
module ctrl_decode
    import sap_pkg::*;
#(
    parameter int OPW           = 4,
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  state_t            state,
    input  logic [OPW-1:0]    opcode,
    input  logic              flag_z,
    input  logic              flag_c,
    output logic [CW_W-1:0]   cw,
    output logic              last,
    output logic              to_halt
);

    logic [3:0] op;
    assign op = 4'(opcode);

    always_comb begin
        cw      = '0;
        last    = 1'b0;
        to_halt = 1'b0;
        case (state)
            ST_FETCH0: begin
                cw[CW_PC_OE]     = 1'b1;
                cw[CW_MAR_WRITE] = 1'b1;
            end
            ST_FETCH1: begin
                cw[CW_RAM_OE]   = 1'b1;
                cw[CW_IR_WRITE] = 1'b1;
                cw[CW_PC_INC]   = 1'b1;
            end
            ST_EXEC0: begin
                case (op)
                    OP_NOP: last = 1'b1;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_ADDR_OE] = 1'b1;
                        cw[CW_MAR_WRITE]  = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_ADDR_OE] = 1'b1;
                        cw[CW_A_WRITE]    = 1'b1;
                        last              = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_ADDR_OE] = 1'b1;
                        cw[CW_PC_LOAD]    = 1'b1;
                        last              = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IR_ADDR_OE] = flag_c;
                        cw[CW_PC_LOAD]    = flag_c;
                        last              = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_ADDR_OE] = flag_z;
                        cw[CW_PC_LOAD]    = flag_z;
                        last              = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OE]      = 1'b1;
                        cw[CW_OUT_WRITE] = 1'b1;
                        last             = 1'b1;
                    end
                    OP_HLT: begin
                        last    = 1'b1;
                        to_halt = 1'b1;
                    end
                    default: begin
                        last    = 1'b1;
                        to_halt = ILLEGAL_HALTS;
                    end
                endcase
            end
            ST_EXEC1: begin
                case (op)
                    OP_LDA: begin
                        cw[CW_RAM_OE]  = 1'b1;
                        cw[CW_A_WRITE] = 1'b1;
                        last           = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OE]  = 1'b1;
                        cw[CW_B_WRITE] = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_A_OE]      = 1'b1;
                        cw[CW_RAM_WRITE] = 1'b1;
                        last             = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_EXEC2: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    cw[CW_ALU_OE]      = 1'b1;
                    cw[CW_A_WRITE]     = 1'b1;
                    cw[CW_FLAGS_WRITE] = 1'b1;
                    cw[CW_ALU_SUB]     = (op == OP_SUB);
                end
                last = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for the 16-bit SAP CPU: state register, next-state
// logic and reset gating around the combinational decoder.
//
//   state   | meaning
//   FETCH0  | PC -> MAR
//   FETCH1  | RAM -> IR, PC++
//   EXEC0   | first execute cycle, opcode and flags decoded
//   EXEC1   | second execute cycle (LDA/STA/ADD/SUB)
//   EXEC2   | third execute cycle (ADD/SUB)
//   HALT    | stopped until reset
module control_sequencer
    import sap_pkg::*;
#(
    parameter int OPW           = 4,
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir_out,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic        pc_oe,
    output logic        ir_addr_oe,
    output logic        ram_oe,
    output logic        a_oe,
    output logic        alu_oe,
    output logic        mar_write,
    output logic        ir_write,
    output logic        a_write,
    output logic        b_write,
    output logic        ram_write,
    output logic        out_write,
    output logic        flags_write,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        alu_sub,
    output logic        instr_done,
    output logic        halted
);

    state_t            state;
    state_t            state_nxt;
    logic [CW_W-1:0]   cw;
    logic [CW_W-1:0]   cw_gated;
    logic              last;
    logic              to_halt;

    // The operand field is consumed by the datapath, not by the controller.
    logic unused_operand;
    assign unused_operand = ^ir_out[15-OPW:0];

    ctrl_decode #(
        .OPW           (OPW),
        .ILLEGAL_HALTS (ILLEGAL_HALTS)
    ) u_decode (
        .state   (state),
        .opcode  (ir_out[15 -: OPW]),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .cw      (cw),
        .last    (last),
        .to_halt (to_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH0: state_nxt = ST_FETCH1;
            ST_FETCH1: state_nxt = ST_EXEC0;
            ST_EXEC0:  state_nxt = to_halt ? ST_HALT : (last ? ST_FETCH0 : ST_EXEC1);
            ST_EXEC1:  state_nxt = to_halt ? ST_HALT : (last ? ST_FETCH0 : ST_EXEC2);
            ST_EXEC2:  state_nxt = to_halt ? ST_HALT : ST_FETCH0;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_FETCH0;
        endcase
    end

    // Outputs are silenced combinationally for the whole reset cycle, so an
    // aborted instruction cannot leak a strobe.
    assign cw_gated    = rst ? '0 : cw;
    assign instr_done  = ~rst & last;
    assign halted      = ~rst & (state == ST_HALT);

    assign pc_oe       = cw_gated[CW_PC_OE];
    assign ir_addr_oe  = cw_gated[CW_IR_ADDR_OE];
    assign ram_oe      = cw_gated[CW_RAM_OE];
    assign a_oe        = cw_gated[CW_A_OE];
    assign alu_oe      = cw_gated[CW_ALU_OE];
    assign mar_write   = cw_gated[CW_MAR_WRITE];
    assign ir_write    = cw_gated[CW_IR_WRITE];
    assign a_write     = cw_gated[CW_A_WRITE];
    assign b_write     = cw_gated[CW_B_WRITE];
    assign ram_write   = cw_gated[CW_RAM_WRITE];
    assign out_write   = cw_gated[CW_OUT_WRITE];
    assign flags_write = cw_gated[CW_FLAGS_WRITE];
    assign pc_inc      = cw_gated[CW_PC_INC];
    assign pc_load     = cw_gated[CW_PC_LOAD];
    assign alu_sub     = cw_gated[CW_ALU_SUB];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (illegal opcodes as NOP / as HALT)
// driven by directed and random instruction streams against a per-instruction table model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir_out;
    logic        flag_z;
    logic        flag_c;
    wire  [16:0] o0;
    wire  [16:0] o1;

    int total = 0;
    int bad   = 0;

    // Observed word layout: {pc_oe, ir_addr_oe, ram_oe, a_oe, alu_oe, mar_write, ir_write,
    // a_write, b_write, ram_write, out_write, flags_write, pc_inc, pc_load, alu_sub, instr_done, halted}
    localparam logic [16:0] PC_OE   = 17'h10000;
    localparam logic [16:0] ADDR_OE = 17'h08000;
    localparam logic [16:0] RAM_OE  = 17'h04000;
    localparam logic [16:0] A_OE    = 17'h02000;
    localparam logic [16:0] ALU_OE  = 17'h01000;
    localparam logic [16:0] MAR_W   = 17'h00800;
    localparam logic [16:0] IR_W    = 17'h00400;
    localparam logic [16:0] A_W     = 17'h00200;
    localparam logic [16:0] B_W     = 17'h00100;
    localparam logic [16:0] RAM_W   = 17'h00080;
    localparam logic [16:0] OUT_W   = 17'h00040;
    localparam logic [16:0] FLAGS_W = 17'h00020;
    localparam logic [16:0] PC_INC  = 17'h00010;
    localparam logic [16:0] PC_LD   = 17'h00008;
    localparam logic [16:0] SUB     = 17'h00004;
    localparam logic [16:0] DONE    = 17'h00002;
    localparam logic [16:0] HALTED  = 17'h00001;
    localparam logic [16:0] F0_WORD = PC_OE | MAR_W;
    localparam logic [16:0] F1_WORD = RAM_OE | IR_W | PC_INC;

    always #5 clk = ~clk;

    control_sequencer #(.OPW(4), .ILLEGAL_HALTS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .ir_out(ir_out), .flag_z(flag_z), .flag_c(flag_c),
        .pc_oe(o0[16]), .ir_addr_oe(o0[15]), .ram_oe(o0[14]), .a_oe(o0[13]), .alu_oe(o0[12]),
        .mar_write(o0[11]), .ir_write(o0[10]), .a_write(o0[9]), .b_write(o0[8]),
        .ram_write(o0[7]), .out_write(o0[6]), .flags_write(o0[5]), .pc_inc(o0[4]),
        .pc_load(o0[3]), .alu_sub(o0[2]), .instr_done(o0[1]), .halted(o0[0])
    );

    control_sequencer #(.OPW(4), .ILLEGAL_HALTS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .ir_out(ir_out), .flag_z(flag_z), .flag_c(flag_c),
        .pc_oe(o1[16]), .ir_addr_oe(o1[15]), .ram_oe(o1[14]), .a_oe(o1[13]), .alu_oe(o1[12]),
        .mar_write(o1[11]), .ir_write(o1[10]), .a_write(o1[9]), .b_write(o1[8]),
        .ram_write(o1[7]), .out_write(o1[6]), .flags_write(o1[5]), .pc_inc(o1[4]),
        .pc_load(o1[3]), .alu_sub(o1[2]), .instr_done(o1[1]), .halted(o1[0])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic bus_ok(input logic [16:0] o);
        return ($countones(o[16:12]) <= 1) && !(o[14] && o[7]);
    endfunction

    // Instruction length in execute cycles, straight from the cycle-count table.
    function automatic int exec_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 2;
            4'h2, 4'h3: return 3;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [16:0] exec_word(input logic [3:0] op, input int k,
                                              input logic fz, input logic fc);
        logic [16:0] w;
        w = '0;
        case (op)
            4'h1: w = (k == 0) ? (ADDR_OE | MAR_W) : (RAM_OE | A_W);
            4'h2, 4'h3: begin
                if (k == 0)      w = ADDR_OE | MAR_W;
                else if (k == 1) w = RAM_OE | B_W;
                else             w = ALU_OE | A_W | FLAGS_W | ((op == 4'h3) ? SUB : 17'h0);
            end
            4'h4: w = (k == 0) ? (ADDR_OE | MAR_W) : (A_OE | RAM_W);
            4'h5: w = ADDR_OE | A_W;
            4'h6: w = ADDR_OE | PC_LD;
            4'h7: w = fc ? (ADDR_OE | PC_LD) : 17'h0;
            4'h8: w = fz ? (ADDR_OE | PC_LD) : 17'h0;
            4'hE: w = A_OE | OUT_W;
            default: w = '0;
        endcase
        if (k == exec_len(op) - 1) w = w | DONE;
        return w;
    endfunction

    // One clock: inputs already driven at the negedge; compare, then advance.
    task automatic cyc(input string tag, input logic [16:0] e0, input logic [16:0] e1);
        #1;
        check_val({tag, "_d0"}, {15'h0, o0}, {15'h0, e0});
        check_val({tag, "_d1"}, {15'h0, o1}, {15'h0, e1});
        check_val({tag, "_bus_d0"}, {31'h0, bus_ok(o0)}, 32'h1);
        check_val({tag, "_bus_d1"}, {31'h0, bus_ok(o1)}, 32'h1);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic fz, input logic fc);
        logic [3:0] op;
        op = ins[15:12];
        rst = 1'b0;
        // Stale/garbage IR and flags during fetch must not matter.
        ir_out = 16'($urandom);
        flag_z = 1'($urandom);
        flag_c = 1'($urandom);
        cyc("fetch0", F0_WORD, F0_WORD);
        ir_out = 16'($urandom);
        cyc("fetch1", F1_WORD, F1_WORD);
        ir_out = ins;
        flag_z = fz;
        flag_c = fc;
        for (int k = 0; k < exec_len(op); k++) begin
            logic [16:0] w;
            w = exec_word(op, k, fz, fc);
            cyc($sformatf("op%h_e%0d", op, k), w, w);
        end
    endtask

    logic [3:0] legal_ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE};

    initial begin
        rst    = 1'b1;
        ir_out = 16'h2005;
        flag_z = 1'b0;
        flag_c = 1'b0;
        repeat (3) cyc("reset", 17'h0, 17'h0);

        run_instr(16'h2007, 1'b0, 1'b0);
        run_instr(16'h3007, 1'b0, 1'b0);
        run_instr(16'h8123, 1'b1, 1'b0);
        run_instr(16'h8123, 1'b0, 1'b1);
        run_instr(16'h7456, 1'b0, 1'b1);
        run_instr(16'h7456, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins;
            ins = {legal_ops[$urandom_range(0, 9)], 12'($urandom)};
            run_instr(ins, 1'($urandom), 1'($urandom));
        end

        // Abort an ADD in its EXEC1 cycle.
        ir_out = 16'($urandom);
        cyc("abort_f0", F0_WORD, F0_WORD);
        cyc("abort_f1", F1_WORD, F1_WORD);
        ir_out = 16'h2007;
        cyc("abort_e0", ADDR_OE | MAR_W, ADDR_OE | MAR_W);
        rst = 1'b1;
        cyc("abort_rst", 17'h0, 17'h0);
        run_instr(16'h0000, 1'b0, 1'b0);

        run_instr(16'hF000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ir_out = 16'($urandom);
            flag_z = 1'($urandom);
            flag_c = 1'($urandom);
            cyc("halt", HALTED, HALTED);
        end
        rst = 1'b1;
        cyc("halt_rst", 17'h0, 17'h0);
        run_instr(16'h5042, 1'b0, 1'b0);

        // Unlisted opcode: NOP on instance 0, HALT on instance 1.
        run_instr(16'hA000, 1'b0, 1'b0);
        cyc("illegal_next0", F0_WORD, HALTED);
        cyc("illegal_next1", F1_WORD, HALTED);
        ir_out = 16'hE000;
        cyc("illegal_next2", A_OE | OUT_W | DONE, HALTED);
        rst = 1'b1;
        cyc("illegal_rst", 17'h0, 17'h0);
        run_instr(16'h1003, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
